fpadd_arbiter: RTL and testbench

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_arbiter.sv | 110 +++++++++++
 tb/tb_fpadd_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter that shares one fpadd pipeline between two requesters,
// tracking each operation with a tag pipeline so results return to their owner.
module fpadd_arbiter #(
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_0,
   input  logic [31:0] req_a_0,
   input  logic [31:0] req_b_0,
   output logic        req_ready_0,
   input  logic        req_valid_1,
   input  logic [31:0] req_a_1,
   input  logic [31:0] req_b_1,
   output logic        req_ready_1,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_result,
   output logic        res_valid_0,
   output logic        res_valid_1,
   output logic [31:0] res_data,
   output logic        busy,
   output logic [15:0] done_count
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   logic              last_grant;
   logic              transfer;
   logic              grant_id;
   logic [LATENCY:0]  tag_valid;
   logic [LATENCY:0]  tag_id;

   // Grant: lone requester wins; on contention the one not granted last time wins.
   always_comb begin
      req_ready_0 = 1'b0;
      req_ready_1 = 1'b0;
      if (!rst) begin
         if (req_valid_0 && (!req_valid_1 || last_grant)) begin
            req_ready_0 = 1'b1;
         end else if (req_valid_1) begin
            req_ready_1 = 1'b1;
         end
      end
   end

   // Handshake decode and occupancy indication.
   always_comb begin
      transfer = req_ready_0 | req_ready_1;
      grant_id = req_ready_1;
      busy     = transfer | (|tag_valid);
   end

   // Round-robin pointer moves only when a transfer actually happens.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (transfer) begin
         last_grant <= grant_id;
      end
   end

   // Operand registers feeding the shared adder; hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         add_a <= DATA_W'(0);
         add_b <= DATA_W'(0);
      end else if (transfer) begin
         add_a <= grant_id ? req_a_1 : req_a_0;
         add_b <= grant_id ? req_b_1 : req_b_0;
      end
   end

   // Tag pipeline; stage LATENCY lines up with add_result for the same operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid <= {tag_valid[LATENCY-1:0], transfer};
         tag_id    <= {tag_id[LATENCY-1:0], grant_id};
      end
   end

   // Capture the sum and steer the one-cycle valid pulse to its owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data    <= DATA_W'(0);
         res_valid_0 <= 1'b0;
         res_valid_1 <= 1'b0;
      end else begin
         res_valid_0 <= tag_valid[LATENCY] & ~tag_id[LATENCY];
         res_valid_1 <= tag_valid[LATENCY] &  tag_id[LATENCY];
         if (tag_valid[LATENCY]) begin
            res_data <= add_result;
         end
      end
   end

   // Completed-operation counter, wraps naturally at full scale.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_count <= CNT_W'(0);
      end else if (res_valid_0 | res_valid_1) begin
         done_count <= done_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter with a behavioural truncating fpadd pipeline.
module tb_fpadd_arbiter;

   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_0, req_valid_1;
   logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
   logic        req_ready_0, req_ready_1;
   logic [31:0] add_a, add_b, add_result, res_data;
   logic        res_valid_0, res_valid_1, busy;
   logic [15:0] done_count;

   fpadd_arbiter #(.LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid_0(req_valid_0), .req_a_0(req_a_0), .req_b_0(req_b_0), .req_ready_0(req_ready_0),
      .req_valid_1(req_valid_1), .req_a_1(req_a_1), .req_b_1(req_b_1), .req_ready_1(req_ready_1),
      .add_a(add_a), .add_b(add_b), .add_result(add_result),
      .res_valid_0(res_valid_0), .res_valid_1(res_valid_1), .res_data(res_data),
      .busy(busy), .done_count(done_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        id;
      logic [31:0] sum;
      int          stamp;
   } exp_t;

   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   bit    chk_en = 1'b1;
   exp_t  exp_q[$];
   int    pulse_cyc[$];
   logic [31:0] pipe [LAT];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Truncating single-precision add for positive normal operands.
   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a, b;
      logic [7:0]  ea, eb, d;
      logic [24:0] ma, mb, s;
      if (x[30:0] >= y[30:0]) begin a = x; b = y; end
      else begin a = y; b = x; end
      ea = a[30:23];
      eb = b[30:23];
      d  = ea - eb;
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]};
      mb = (d > 8'd24) ? 25'd0 : (mb >> d);
      s  = ma + mb;
      if (s[24]) begin
         s  = s >> 1;
         ea = ea + 8'd1;
      end
      return {1'b0, ea, s[22:0]};
   endfunction

   initial begin
      for (int i = 0; i < int'(LAT); i++) pipe[i] = 32'h0;
   end

   // Behavioural adder pipeline: result appears LAT edges after operands.
   always @(posedge clk) begin
      pipe[0] <= fadd(add_a, add_b);
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
   end
   assign add_result = pipe[LAT-1];

   // Scoreboard producer: record accepted operations at the transfer edge.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (req_valid_0 || req_valid_1)
            check("ready_excl", 32'(req_ready_0 & req_ready_1), 32'h0);
         if (req_valid_0 && req_ready_0) exp_q.push_back('{1'b0, fadd(req_a_0, req_b_0), cyc});
         if (req_valid_1 && req_ready_1) exp_q.push_back('{1'b1, fadd(req_a_1, req_b_1), cyc});
      end
      cyc++;
   end

   // Scoreboard consumer: every result pulse must match the oldest accepted op.
   always @(negedge clk) begin
      if (res_valid_0 || res_valid_1) begin
         exp_t e;
         pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("spurious_res", 32'h1, 32'h0);
         end else begin
            e = exp_q.pop_front();
            if (chk_en) begin
               check("res_excl", 32'(res_valid_0 & res_valid_1), 32'h0);
               check("res_id", 32'(res_valid_1), 32'(e.id));
               check("res_data", res_data, e.sum);
               check("res_latency", 32'(cyc), 32'(e.stamp + int'(LAT) + 2));
            end
         end
      end
   end

   task automatic idle_inputs();
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0 && !res_valid_0 && !res_valid_1) done = 1'b1;
      end
      if (!done) check("drain_timeout", 32'h1, 32'h0);
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      idle_inputs();
      req_a_0 = 32'h0; req_b_0 = 32'h0; req_a_1 = 32'h0; req_b_1 = 32'h0;
      req_valid_0 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready0", 32'(req_ready_0), 32'h0);
      check("rst_add_a", add_a, 32'h0);
      check("rst_add_b", add_b, 32'h0);
      check("rst_res_data", res_data, 32'h0);
      check("rst_res_valid", 32'({res_valid_1, res_valid_0}), 32'h0);
      check("rst_done", 32'(done_count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req_valid_0 = 1'b0;

      // Single request with known sum.
      @(negedge clk);
      req_valid_0 = 1'b1; req_a_0 = 32'h6b64b235; req_b_0 = 32'h6ac49214;
      #1;
      check("single_ready0", 32'(req_ready_0), 32'h1);
      check("single_busy", 32'(busy), 32'h1);
      @(negedge clk);
      req_valid_0 = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (res_valid_0) found = 1'b1;
      end
      check("single_seen", 32'(found), 32'h1);
      check("single_sum", res_data, 32'h6ba37d9f);
      drain();
      check("single_done", 32'(done_count), 32'h1);
      check("single_busy_after", 32'(busy), 32'h0);

      // Contention straight after reset: grants alternate starting with 0.
      do_reset();
      pulse_cyc.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req_valid_0 = 1'b1; req_a_0 = 32'h3f800000 + (i << 16); req_b_0 = 32'h40000000;
         req_valid_1 = 1'b1; req_a_1 = 32'h41200000 + (i << 12); req_b_1 = 32'h3f000000;
         #1;
         check("cont_ready0", 32'(req_ready_0), 32'((i % 2) == 0));
         check("cont_ready1", 32'(req_ready_1), 32'((i % 2) == 1));
      end
      @(negedge clk);
      idle_inputs();
      drain();
      check("cont_pulses", 32'(pulse_cyc.size()), 32'd6);
      if (pulse_cyc.size() == 6) check("cont_no_gap", 32'(pulse_cyc[5] - pulse_cyc[0]), 32'd5);
      check("cont_done", 32'(done_count), 32'd6);

      // Back-to-back single requester.
      pulse_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req_valid_1 = 1'b1; req_a_1 = 32'h3f800000 + (i << 16); req_b_1 = 32'h40000000 + (i << 12);
         #1;
         check("b2b_ready1", 32'(req_ready_1), 32'h1);
      end
      @(negedge clk);
      idle_inputs();
      drain();
      check("b2b_pulses", 32'(pulse_cyc.size()), 32'd8);
      if (pulse_cyc.size() == 8) check("b2b_no_gap", 32'(pulse_cyc[7] - pulse_cyc[0]), 32'd7);

      // Hold while idle, then next contended grant goes to requester 1.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid_0 = 1'b1; req_a_0 = 32'h40400000 + (i << 8); req_b_0 = 32'h3fc00000 + (i << 8);
      end
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("hold_ready", 32'({req_ready_1, req_ready_0}), 32'h0);
         check("hold_add_a", add_a, 32'h40400200);
         check("hold_add_b", add_b, 32'h3fc00200);
         @(negedge clk);
      end
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      req_a_1 = 32'h40a00000; req_b_1 = 32'h40a00000;
      #1;
      check("hold_next_grant", 32'({req_ready_1, req_ready_0}), 32'h2);
      @(negedge clk);
      #1;
      check("hold_add_a_load", add_a, 32'h40a00000);
      check("hold_grant_after", 32'({req_ready_1, req_ready_0}), 32'h1);
      @(negedge clk);
      idle_inputs();
      drain();

      // Reset one cycle before the first result discards everything in flight.
      pulse_cyc.delete();
      @(negedge clk);
      req_valid_0 = 1'b1; req_a_0 = 32'h3f800000; req_b_0 = 32'h3f800000;
      repeat (3) @(negedge clk);
      req_valid_0 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_flight_pulses", 32'(pulse_cyc.size()), 32'h0);
      check("rst_flight_done", 32'(done_count), 32'h0);
      check("rst_flight_busy", 32'(busy), 32'h0);

      // Counter wrap via real completions.
      do_reset();
      chk_en = 1'b0;
      @(negedge clk);
      req_valid_0 = 1'b1; req_a_0 = 32'h3f800000; req_b_0 = 32'h40000000;
      repeat (65535) @(negedge clk);
      idle_inputs();
      drain();
      check("wrap_full", 32'(done_count), 32'h0000ffff);
      @(negedge clk);
      req_valid_0 = 1'b1;
      @(negedge clk);
      idle_inputs();
      drain();
      check("wrap_zero", 32'(done_count), 32'h0);
      chk_en = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
